// File: rtl/rst_seq_ctrl.sv
// Power-up / reset sequencer: releases PUONOUT, CE0, RESB and CPURSOUTB in order
// and re-runs the release on a filtered external reset, software request or lock loss.
module rst_seq_ctrl #(
    parameter int PU_CYCLES   = 16,
    parameter int RES_CYCLES  = 8,
    parameter int CPU_CYCLES  = 4,
    parameter int FILT_CYCLES = 3,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ext_resb_n,
    input  logic       sw_rst_req,
    input  logic       pll_lock,
    output logic       PUONOUT,
    output logic       CE0,
    output logic       RESB,
    output logic       CPURSOUTB,
    output logic [2:0] seq_state,
    output logic [7:0] restart_cnt
);

    localparam logic [2:0] ST_PU    = 3'd0;
    localparam logic [2:0] ST_WLOCK = 3'd1;
    localparam logic [2:0] ST_RES   = 3'd2;
    localparam logic [2:0] ST_CPU   = 3'd3;
    localparam logic [2:0] ST_RUN   = 3'd4;

    localparam logic [CNT_W-1:0] PU_LOAD  = CNT_W'(PU_CYCLES - 1);
    localparam logic [CNT_W-1:0] RES_LOAD = CNT_W'(RES_CYCLES - 1);
    localparam logic [CNT_W-1:0] CPU_LOAD = CNT_W'(CPU_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       FILT_MAX = 4'(FILT_CYCLES);

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       ext_sync, lock_sync;
    logic             ext_resb_s, lock_s;
    logic [3:0]       filt_cnt;
    logic             filt_req;
    logic             restart;

    // Synchronisers reset to the "no request" / "not locked" levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_sync  <= 2'b11;
            lock_sync <= 2'b00;
        end else begin
            // NOTE: non-blocking so both flops of each chain sample pre-edge values.
            ext_sync  <= {ext_sync[0], ext_resb_n};
            lock_sync <= {lock_sync[0], pll_lock};
        end
    end

    assign ext_resb_s = ext_sync[1];
    assign lock_s     = lock_sync[1];

    // Counter saturates at FILT_MAX, so one low assertion yields one filt_req pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_cnt <= 4'd0;
            filt_req <= 1'b0;
        end else if (ext_resb_s) begin
            filt_cnt <= 4'd0;
            filt_req <= 1'b0;
        end else if (filt_cnt != FILT_MAX) begin
            filt_cnt <= filt_cnt + 4'd1;
            filt_req <= (filt_cnt == FILT_MAX - 4'd1);
        end else begin
            filt_req <= 1'b0;
        end
    end

    // Lock is not a restart cause while already waiting for it.
    always_comb begin
        case (state)
            ST_WLOCK:              restart = filt_req | sw_rst_req;
            ST_RES, ST_CPU, ST_RUN: restart = filt_req | sw_rst_req | ~lock_s;
            default:               restart = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latches).
        state_nxt = state;
        cnt_nxt   = cnt;
        if (restart) begin
            state_nxt = ST_WLOCK;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_PU: begin
                    if (cnt == '0) state_nxt = ST_WLOCK;
                    else           cnt_nxt   = cnt - CNT_ONE;
                end
                ST_WLOCK: begin
                    if (lock_s) begin
                        state_nxt = ST_RES;
                        cnt_nxt   = RES_LOAD;
                    end
                end
                ST_RES: begin
                    if (cnt == '0) begin
                        state_nxt = ST_CPU;
                        cnt_nxt   = CPU_LOAD;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
                ST_CPU: begin
                    if (cnt == '0) state_nxt = ST_RUN;
                    else           cnt_nxt   = cnt - CNT_ONE;
                end
                ST_RUN: begin
                end
                default: begin
                    state_nxt = ST_WLOCK;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Qualifiers are flopped from the next-state decode so they change on the
    // same edge as the state register and are glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_PU;
            cnt         <= PU_LOAD;
            PUONOUT     <= 1'b0;
            CE0         <= 1'b0;
            RESB        <= 1'b0;
            CPURSOUTB   <= 1'b0;
            restart_cnt <= 8'd0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            PUONOUT   <= (state_nxt == ST_WLOCK) || (state_nxt == ST_RES) ||
                         (state_nxt == ST_CPU)   || (state_nxt == ST_RUN);
            CE0       <= (state_nxt == ST_RES) || (state_nxt == ST_CPU) || (state_nxt == ST_RUN);
            RESB      <= (state_nxt == ST_CPU) || (state_nxt == ST_RUN);
            CPURSOUTB <= (state_nxt == ST_RUN);
            if (restart && (restart_cnt != 8'hFF)) begin
                restart_cnt <= restart_cnt + 8'd1;
            end
        end
    end

    assign seq_state = state;

endmodule
